sys_host_master: RTL

//  Bus initiator for the systolic array's RAM interface (ren/radr/rdata, wen/wadr/wdata).

---
 rtl/sys_host_master.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sys_host_master.sv
// rtl/sys_host_master.sv - bus initiator driving a full systolic job over the ren/wen RAM bus
// Loads A/B operands from a word stream, kicks the control register, polls status, streams results out.
module sys_host_master #(
    parameter logic [15:0] A_BASE    = 16'h0000,
    parameter logic [15:0] B_BASE    = 16'h0100,
    parameter int          N_WORDS   = 8,
    parameter logic [15:0] CTRL_ADR  = 16'h0200,
    parameter logic [15:0] STAT_ADR  = 16'h0201,
    parameter logic [15:0] RES_BASE  = 16'h0300,
    parameter int          RES_WORDS = 4,
    parameter int          POLL_MAX  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_go,
    input  logic [7:0]  cmd_cntr,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        ren,
    output logic [15:0] ibus_radr,
    input  logic [15:0] ibus_rdata,
    output logic        wen,
    output logic [15:0] ibus_wadr,
    output logic [15:0] ibus_wdata
);

    localparam int IW = $clog2(N_WORDS + 1);
    localparam int RW = $clog2(RES_WORDS + 1);
    localparam int PW = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOAD_A    = 4'd1,
        S_LOAD_B    = 4'd2,
        S_KICK      = 4'd3,
        S_POLL_RD   = 4'd4,
        S_POLL_WAIT = 4'd5,
        S_READ_RD   = 4'd6,
        S_READ_WAIT = 4'd7,
        S_OUT_HOLD  = 4'd8,
        S_DONE      = 4'd9
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_idx;
    logic [RW-1:0]   r_ridx;
    logic [PW-1:0]   r_poll_cnt;
    logic [7:0]      r_cntr;
    logic            r_timeout;
    logic [15:0]     r_out_data;
    logic            r_ld_wen;
    logic [15:0]     r_ld_wadr;
    logic [15:0]     r_ld_wdata;
    logic            w_in_hs;
    logic            w_a_last;
    logic            w_b_full;
    logic            w_poll_exhausted;
    logic            w_res_last;

    assign w_in_hs          = in_valid && in_ready;
    assign w_a_last         = (r_idx == IW'(N_WORDS - 1));
    assign w_b_full         = (r_idx == IW'(N_WORDS));
    assign w_poll_exhausted = (r_poll_cnt == PW'(POLL_MAX));
    assign w_res_last       = (r_ridx == RW'(RES_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // LOAD_B lingers one cycle with in_ready low so the last operand write
    // and the control write never share a cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (cmd_go) w_next = S_LOAD_A;
            S_LOAD_A:    if (w_in_hs && w_a_last) w_next = S_LOAD_B;
            S_LOAD_B:    if (w_b_full) w_next = S_KICK;
            S_KICK:      w_next = S_POLL_RD;
            S_POLL_RD:   w_next = S_POLL_WAIT;
            S_POLL_WAIT: begin
                if (ibus_rdata[0])          w_next = S_READ_RD;
                else if (w_poll_exhausted)  w_next = S_DONE;
                else                        w_next = S_POLL_RD;
            end
            S_READ_RD:   w_next = S_READ_WAIT;
            S_READ_WAIT: w_next = S_OUT_HOLD;
            S_OUT_HOLD:  if (out_ready) w_next = w_res_last ? S_DONE : S_READ_RD;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != S_IDLE);
        done       = (r_state == S_DONE);
        timeout    = r_timeout;
        in_ready   = (r_state == S_LOAD_A) || ((r_state == S_LOAD_B) && !w_b_full);
        out_valid  = (r_state == S_OUT_HOLD);
        out_data   = r_out_data;
        ren        = 1'b0;
        ibus_radr  = 16'h0000;
        wen        = r_ld_wen;
        ibus_wadr  = r_ld_wen ? r_ld_wadr  : 16'h0000;
        ibus_wdata = r_ld_wen ? r_ld_wdata : 16'h0000;
        case (r_state)
            S_POLL_RD: begin
                ren       = 1'b1;
                ibus_radr = STAT_ADR;
            end
            S_READ_RD: begin
                ren       = 1'b1;
                ibus_radr = RES_BASE + 16'(r_ridx);
            end
            S_KICK: begin
                wen        = 1'b1;
                ibus_wadr  = CTRL_ADR;
                ibus_wdata = {8'h01, r_cntr};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_ridx     <= '0;
            r_poll_cnt <= '0;
            r_cntr     <= 8'h00;
            r_timeout  <= 1'b0;
            r_out_data <= 16'h0000;
            r_ld_wen   <= 1'b0;
            r_ld_wadr  <= 16'h0000;
            r_ld_wdata <= 16'h0000;
        end else begin
            r_ld_wen <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_go) begin
                        r_cntr     <= cmd_cntr;
                        r_timeout  <= 1'b0;
                        r_idx      <= '0;
                        r_ridx     <= '0;
                        r_poll_cnt <= '0;
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (w_in_hs) begin
                        r_ld_wen   <= 1'b1;
                        r_ld_wadr  <= ((r_state == S_LOAD_A) ? A_BASE : B_BASE) + 16'(r_idx);
                        r_ld_wdata <= in_data;
                        r_idx      <= ((r_state == S_LOAD_A) && w_a_last) ? '0 : r_idx + 1'b1;
                    end
                end
                S_POLL_RD: r_poll_cnt <= r_poll_cnt + 1'b1;
                S_POLL_WAIT: begin
                    if (!ibus_rdata[0] && w_poll_exhausted) r_timeout <= 1'b1;
                end
                S_READ_WAIT: r_out_data <= ibus_rdata;
                S_OUT_HOLD: begin
                    if (out_ready) r_ridx <= r_ridx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
